// File: rtl/temporal_decoder_if.sv
// Stream bundle for the temporal decoder: encoded HVs in, decoded HVs out,
// plus the sequence-boundary control that resets the rebuilt history.
interface temporal_decoder_if #(
    parameter int HV_DIMENSION = 8
);
    logic                    seq_clear;
    logic                    hvin_valid;
    logic                    hvin_ready;
    logic [HV_DIMENSION-1:0] hvin;
    logic                    hvout_valid;
    logic                    hvout_ready;
    logic [HV_DIMENSION-1:0] hvout;

    modport master (
        output seq_clear, hvin_valid, hvin, hvout_ready,
        input  hvin_ready, hvout_valid, hvout
    );

    modport slave (
        input  seq_clear, hvin_valid, hvin, hvout_ready,
        output hvin_ready, hvout_valid, hvout
    );
endinterface

// File: rtl/temporal_decoder.sv
// Inverse n-gram temporal encoder: x_t = y_t ^ (x_{t-1}>>1) ^ ... ^ (x_{t-N+1}>>(N-1)),
// with the shifted history rebuilt locally from previously decoded vectors.
module temporal_decoder #(
    parameter int HV_DIMENSION = 8,
    parameter int NGRAM_SIZE   = 3
) (
    input  logic                clk,
    input  logic                rst,
    temporal_decoder_if.slave   bus
);
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] COMPUTE = 2'd1;
    localparam logic [1:0] OUT     = 2'd2;

    logic [1:0]              state_reg;
    logic [1:0]              state_next;
    logic [HV_DIMENSION-1:0] y_reg;
    logic [HV_DIMENSION-1:0] x_reg;
    logic [HV_DIMENSION-1:0] hist_reg  [1:NGRAM_SIZE-1];
    logic [HV_DIMENSION-1:0] hist_next [1:NGRAM_SIZE-1];
    logic [HV_DIMENSION-1:0] hist_xor;

    logic in_fire;
    logic out_fire;

    assign bus.hvin_ready  = (state_reg == IDLE);
    assign bus.hvout_valid = (state_reg == OUT);
    assign bus.hvout       = x_reg;

    assign in_fire  = bus.hvin_valid  && (state_reg == IDLE);
    assign out_fire = bus.hvout_ready && (state_reg == OUT);

    // hist[i] mirrors the encoder's ngram[i] = x_{t-i} >> i.
    genvar gi;
    generate
        for (gi = 1; gi < NGRAM_SIZE; gi++) begin : g_hist
            if (gi == 1) begin : g_first
                assign hist_next[gi] = x_reg >> 1;
            end else begin : g_rest
                assign hist_next[gi] = hist_reg[gi-1] >> 1;
            end
        end
    endgenerate

    always_comb begin
        hist_xor = '0;
        for (int i = 1; i < NGRAM_SIZE; i++) begin
            hist_xor = hist_xor ^ hist_reg[i];
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (in_fire)  state_next = COMPUTE;
            COMPUTE: state_next = OUT;
            OUT:     if (out_fire) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            y_reg     <= '0;
            x_reg     <= '0;
        end else begin
            state_reg <= state_next;
            if (in_fire) begin
                y_reg <= bus.hvin;
            end
            // A clear landing in COMPUTE must decode against the cleared history.
            if (state_reg == COMPUTE) begin
                x_reg <= bus.seq_clear ? y_reg : (y_reg ^ hist_xor);
            end
        end
    end

    // Clear wins over the history shift when both happen on the same edge.
    always_ff @(posedge clk) begin
        for (int i = 1; i < NGRAM_SIZE; i++) begin
            if (rst || bus.seq_clear) begin
                hist_reg[i] <= '0;
            end else if (out_fire) begin
                hist_reg[i] <= hist_next[i];
            end
        end
    end
endmodule

// File: tb/tb_temporal_decoder.sv
// Directed and loopback checks for temporal_decoder (HV_DIMENSION=8, NGRAM_SIZE=3).
module tb_temporal_decoder;
    localparam int W = 8;
    localparam int N = 3;

    logic clk;
    logic rst;

    temporal_decoder_if #(.HV_DIMENSION(W)) bus ();

    temporal_decoder #(.HV_DIMENSION(W), .NGRAM_SIZE(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] y;
        bit           clr;
        logic [W-1:0] x;
    } vec_t;

    vec_t vecs [8];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic pulse_clear();
        @(negedge clk);
        bus.seq_clear = 1'b1;
        @(negedge clk);
        bus.seq_clear = 1'b0;
    endtask

    // One transfer: fire at edge k, COMPUTE after k, OUT after k+1, output fires
    // at k+2 unless stalled. Optional clear during COMPUTE.
    task automatic xfer(input string name, input logic [W-1:0] y, input logic [W-1:0] exp,
                        input bit clr_in_compute, input int stall, input bit verbose);
        @(negedge clk);
        check({name, " in_ready"}, 32'(bus.hvin_ready), 32'd1);
        bus.hvin_valid = 1'b1;
        bus.hvin       = y;
        @(posedge clk);
        #1;
        bus.hvin_valid = 1'b0;
        bus.hvin       = ~y;
        if (clr_in_compute) bus.seq_clear = 1'b1;
        if (stall > 0) bus.hvout_ready = 1'b0;
        check({name, " compute_valid"}, 32'(bus.hvout_valid), 32'd0);
        check({name, " compute_ready"}, 32'(bus.hvin_ready), 32'd0);
        @(posedge clk);
        #1;
        bus.seq_clear = 1'b0;
        check({name, " out_valid"}, 32'(bus.hvout_valid), 32'd1);
        check({name, " hvout"}, 32'(bus.hvout), 32'(exp));
        for (int s = 0; s < stall; s++) begin
            bus.hvin_valid = 1'b1;
            bus.hvin       = 8'h5A;
            @(posedge clk);
            #1;
            check({name, " stall_valid"}, 32'(bus.hvout_valid), 32'd1);
            check({name, " stall_hvout"}, 32'(bus.hvout), 32'(exp));
            check({name, " stall_ready"}, 32'(bus.hvin_ready), 32'd0);
        end
        bus.hvin_valid  = 1'b0;
        bus.hvout_ready = 1'b1;
        @(posedge clk);
        #1;
        check({name, " post_valid"}, 32'(bus.hvout_valid), 32'd0);
        check({name, " post_ready"}, 32'(bus.hvin_ready), 32'd1);
        if (verbose) $display("xfer %s: y=%h x=%h expected=%h", name, y, bus.hvout, exp);
    endtask

    logic [W-1:0] enc_hist [1:N-1];
    logic [W-1:0] lx;
    logic [W-1:0] ly;

    initial begin
        vecs[0] = '{y: 8'hA5, clr: 1'b0, x: 8'hA5};
        vecs[1] = '{y: 8'hFF, clr: 1'b0, x: 8'hAD};
        vecs[2] = '{y: 8'h00, clr: 1'b0, x: 8'h7F};
        vecs[3] = '{y: 8'hA5, clr: 1'b1, x: 8'hA5};
        vecs[4] = '{y: 8'hFF, clr: 1'b1, x: 8'hFF};
        vecs[5] = '{y: 8'h01, clr: 1'b0, x: 8'h7E};
        vecs[6] = '{y: 8'h80, clr: 1'b0, x: 8'h80};
        vecs[7] = '{y: 8'h00, clr: 1'b0, x: 8'h5F};

        rst             = 1'b1;
        bus.seq_clear   = 1'b0;
        bus.hvin_valid  = 1'b0;
        bus.hvin        = '0;
        bus.hvout_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset in_ready", 32'(bus.hvin_ready), 32'd1);
        check("reset out_valid", 32'(bus.hvout_valid), 32'd0);
        check("reset hvout", 32'(bus.hvout), 32'h00);
        $display("xfer reset: hvin_ready=%b hvout_valid=%b hvout=%h",
                 bus.hvin_ready, bus.hvout_valid, bus.hvout);

        for (int i = 0; i < 8; i++) begin
            if (vecs[i].clr) pulse_clear();
            xfer($sformatf("vec%0d", i), vecs[i].y, vecs[i].x, 1'b0, 0, 1'b1);
        end

        // Backpressure: history must advance only once for the stalled output.
        pulse_clear();
        xfer("stall", 8'h3C, 8'h3C, 1'b0, 5, 1'b1);
        xfer("after_stall", 8'hFF, 8'hE1, 1'b0, 0, 1'b1);

        // Reset while in OUT drops the HV and the pending history update.
        @(negedge clk);
        bus.hvin_valid = 1'b1;
        bus.hvin       = 8'h11;
        bus.hvout_ready = 1'b0;
        @(posedge clk);
        #1;
        bus.hvin_valid = 1'b0;
        @(posedge clk);
        #1;
        check("pre_rst out_valid", 32'(bus.hvout_valid), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.hvout_ready = 1'b1;
        check("rst_out out_valid", 32'(bus.hvout_valid), 32'd0);
        check("rst_out in_ready", 32'(bus.hvin_ready), 32'd1);
        check("rst_out hvout", 32'(bus.hvout), 32'h00);
        $display("xfer rst_in_out: hvout_valid=%b hvout=%h", bus.hvout_valid, bus.hvout);
        xfer("after_rst", 8'h3C, 8'h3C, 1'b0, 0, 1'b1);

        // Clear during COMPUTE: current HV decodes against zero history.
        xfer("clr_compute", 8'hFF, 8'hFF, 1'b1, 0, 1'b1);
        xfer("after_clr_compute", 8'h00, 8'h7F, 1'b0, 0, 1'b1);

        // Loopback from a common zero history through a behavioural encoder.
        pulse_clear();
        for (int i = 1; i < N; i++) enc_hist[i] = '0;
        for (int t = 0; t < 1000; t++) begin
            lx = W'($urandom);
            ly = lx;
            for (int i = 1; i < N; i++) ly = ly ^ enc_hist[i];
            for (int i = N - 1; i >= 2; i--) enc_hist[i] = enc_hist[i-1] >> 1;
            enc_hist[1] = lx >> 1;
            xfer($sformatf("loop%0d", t), ly, lx, 1'b0, 0, 1'b0);
        end
        $display("xfer loopback: 1000 HVs streamed");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
